// File: rtl/enigma_pkg.sv
// ============================================================================
// Module   : enigma_pkg
// Brief    : Shared constants and FSM state type for the rotor stepper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package enigma_pkg;

  localparam int LETTER_MAX       = 25;
  localparam int POS_W            = 7;
  localparam int INIT_W           = 5;
  localparam int NOTCH_RIGHT_DEF  = 21;
  localparam int NOTCH_MID_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } step_state_t;

  // Out-of-range initial letters load as 0 for that rotor only.
  function automatic logic [POS_W-1:0] clamp_init(input logic [INIT_W-1:0] val);
    logic [POS_W-1:0] ext;
    ext = {{(POS_W-INIT_W){1'b0}}, val};
    return (ext > POS_W'(LETTER_MAX)) ? '0 : ext;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod26_inc.sv
// ============================================================================
// Module   : mod26_inc
// Brief    : Combinational modulo-26 incrementer with enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod26_inc
  import enigma_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  output logic [POS_W-1:0] pos_next
);

  always_comb begin
    pos_next = pos;
    if (en) begin
      pos_next = (pos >= POS_W'(LETTER_MAX)) ? '0 : pos + POS_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rotor_stepper.sv
// ============================================================================
// Module   : rotor_stepper
// Brief    : Three-rotor stepping controller; ROTOR_DOUBLE_STEP_EN selects
//            historical double-stepping instead of a pure odometer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int NOTCH_RIGHT = NOTCH_RIGHT_DEF,
  parameter int NOTCH_MID   = NOTCH_MID_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              load_init,
  input  logic [INIT_W-1:0] init_left,
  input  logic [INIT_W-1:0] init_mid,
  input  logic [INIT_W-1:0] init_right,
  output logic [POS_W-1:0]  pos_left,
  output logic [POS_W-1:0]  pos_mid,
  output logic [POS_W-1:0]  pos_right,
  output logic              step_done
);

  step_state_t      state;
  step_state_t      state_next;
  logic             right_notch;
  logic             mid_notch;
  logic             en_mid;
  logic             en_left;
  logic [POS_W-1:0] left_next;
  logic [POS_W-1:0] mid_next;
  logic [POS_W-1:0] right_next;

  // Notch decisions look at the positions before this step is applied.
  assign right_notch = (pos_right == POS_W'(NOTCH_RIGHT));
  assign mid_notch   = (pos_mid   == POS_W'(NOTCH_MID));

`ifdef ROTOR_DOUBLE_STEP_EN
  assign en_mid  = right_notch | mid_notch;
  assign en_left = mid_notch;
`else
  assign en_mid  = right_notch;
  assign en_left = right_notch & mid_notch;
`endif

  mod26_inc u_inc_right (
    .pos      (pos_right),
    .en       (1'b1),
    .pos_next (right_next)
  );

  mod26_inc u_inc_mid (
    .pos      (pos_mid),
    .en       (en_mid),
    .pos_next (mid_next)
  );

  mod26_inc u_inc_left (
    .pos      (pos_left),
    .en       (en_left),
    .pos_next (left_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    step_done  = 1'b0;
    case (state)
      IDLE: begin
        key_ready = ~load_init;
        if (key_valid && !load_init) begin
          state_next = STEP;
        end
      end
      STEP: state_next = DONE;
      DONE: begin
        step_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A load discards whatever step was in flight.
    if (load_init) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_left  <= '0;
      pos_mid   <= '0;
      pos_right <= '0;
    end else if (load_init) begin
      pos_left  <= clamp_init(init_left);
      pos_mid   <= clamp_init(init_mid);
      pos_right <= clamp_init(init_right);
    end else if (state == STEP) begin
      pos_left  <= left_next;
      pos_mid   <= mid_next;
      pos_right <= right_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/rotor_stepper.md
ROTOR_STEPPER -- requirements
Module: rotor_stepper

Interface
- REQ-001 Parameter NOTCH_RIGHT, default 21, right-rotor position whose departure steps the middle rotor.
- REQ-002 Parameter NOTCH_MID, default 4, middle-rotor position whose departure steps the left rotor.
- REQ-003 clk  input  1  the single clock; all state updates on the posedge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 key_valid  input  1  keypress request; accepted when key_valid and key_ready are both 1 at a posedge.
- REQ-006 key_ready  output  1  high only in IDLE with load_init low.
- REQ-007 load_init  input  1  synchronous load of the initial positions.
- REQ-008 init_left, init_mid, init_right  input  5 each  initial positions.
- REQ-009 pos_left, pos_mid, pos_right  output  7 each  current rotor positions 0-25, zero-extended.
- REQ-010 step_done  output  1  one-cycle pulse after the positions update.

Function
- REQ-011 FSM states: IDLE, STEP, DONE.
- REQ-012 IDLE->STEP on an accepted key; STEP->DONE unconditionally; DONE->IDLE unconditionally.
- REQ-013 Positions update at the posedge that leaves STEP; step_done is 1 only in DONE.
- REQ-014 Latency: key accepted at edge E0, new positions visible after E1, step_done high between E1 and E2, key_ready high again after E2.
- REQ-015 Stepping decisions use the pre-step positions: r_n = (pos_right==NOTCH_RIGHT), m_n = (pos_mid==NOTCH_MID).
- REQ-016 The right rotor advances on every step.
- REQ-017 All increments wrap 25->0; positions never leave 0-25.
- REQ-018 load_init has priority over every state: all three positions load, FSM goes to IDLE, and any in-flight step is discarded with no step_done.
- REQ-019 Any init value above 25 loads as 0 for that rotor only.
- REQ-020 key_valid is ignored outside IDLE and in the cycle load_init is high; a held key_valid steps once per 3 cycles.

Reset
- REQ-021 reset overrides load_init and key_valid.
- REQ-022 On reset, all positions are 0, the FSM is in IDLE, step_done is 0, and key_ready is 1 in the following cycle.
- REQ-023 Reset asserted in STEP or DONE aborts the step: no position change and no step_done.

Configuration
- REQ-024 The macro is ROTOR_DOUBLE_STEP_EN.
- REQ-025 Defined: middle advances if r_n or m_n, and left advances if m_n (historical double-step).
- REQ-026 Undefined: pure odometer; middle advances if r_n, and left advances if r_n and m_n.

Structure
- REQ-027 Package enigma_pkg holds LETTER_MAX=25, the position width 7, the default notch constants, and the FSM state enum.
- REQ-028 One sub-module mod26_inc is instantiated three times; it is combinational, takes a position and an enable, and returns the position, incremented and wrapped when enabled.

Verification
- REQ-029 Reset, then read -> positions 0,0,0, step_done 0; one key -> 0,0,1 with step_done pulsed exactly once at E1-E2.
- REQ-030 Load 0,3,20 (DOUBLE_STEP_EN), three keys -> 0,3,21; 0,4,22; 1,5,23.
- REQ-031 Same load without the macro, three keys -> 0,3,21; 0,4,22; 0,4,23.
- REQ-032 Load 25,25,25 with notches 25/25, one key -> 0,0,0 (triple wrap).
- REQ-033 Load init_mid=30, others 2 -> 2,0,2; load_init asserted during STEP -> loaded values, no step_done.
- REQ-034 key_valid held high for 9 cycles from IDLE at 0,0,0 -> exactly 3 steps, ending at 0,0,3; reset in STEP -> 0,0,0 and no pulse.
